// File: rtl/hazard_unit_ml.sv
// hazard_unit_ml: multi-cycle load-use and branch-flush hazard unit.
// An age-indexed scoreboard tracks loads that have left EX but whose data
// is not yet forwardable. A down-counter holds the flush shadow after a
// taken branch/jump. Flush always wins over a load-use stall because the
// instruction sitting in ID is then on the wrong path.
module hazard_unit_ml #(
    parameter int REG_AW     = 5,
    parameter int LOAD_LAT   = 1,
    parameter int BR_PENALTY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] ID_readReg1,
    input  logic [REG_AW-1:0] ID_readReg2,
    input  logic              ID_useReg1,
    input  logic              ID_useReg2,
    input  logic [REG_AW-1:0] EX_writeReg,
    input  logic              EX_regWrite,
    input  logic [1:0]        EX_memtoReg,
    input  logic              EX_PCSrc,
    output logic              stallPC,
    output logic              IFID_stall,
    output logic              IFID_flush,
    output logic              IDEX_flush,
    output logic              sb_busy
);

    // At least one physical stage so the arrays stay legal when LOAD_LAT==1;
    // that stage is then tied off to invalid.
    localparam int SB_N = (LOAD_LAT > 1) ? (LOAD_LAT - 1) : 1;
    localparam int FW   = $clog2(BR_PENALTY) + 1;

    logic                          ex_load;
    logic [SB_N-1:0]               sb_valid;
    logic [SB_N-1:0][REG_AW-1:0]   sb_reg;
    logic [FW-1:0]                 fcnt;
    logic                          hit1;
    logic                          hit2;
    logic                          raw_stall;
    logic                          flush_now;
    logic                          lw_stall;

    assign ex_load = (EX_memtoReg == 2'b01) && EX_regWrite &&
                     (EX_writeReg != {REG_AW{1'b0}});

    generate
        if (LOAD_LAT > 1) begin : g_sb
            // Scoreboard shift: free-running, never stalled or flushed.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sb_valid <= {SB_N{1'b0}};
                    sb_reg   <= {(SB_N*REG_AW){1'b0}};
                end else begin
                    sb_valid[0] <= ex_load;
                    sb_reg[0]   <= EX_writeReg;
                    for (int k = 1; k < SB_N; k++) begin
                        sb_valid[k] <= sb_valid[k-1];
                        sb_reg[k]   <= sb_reg[k-1];
                    end
                end
            end
        end else begin : g_no_sb
            assign sb_valid = {SB_N{1'b0}};
            assign sb_reg   = {(SB_N*REG_AW){1'b0}};
        end
    endgenerate

    // Flush shadow counter: reload on every taken branch, else count down.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fcnt <= {FW{1'b0}};
        end else if (EX_PCSrc) begin
            fcnt <= FW'(BR_PENALTY - 1);
        end else if (fcnt != {FW{1'b0}}) begin
            fcnt <= fcnt - FW'(1);
        end else begin
            fcnt <= fcnt;
        end
    end

    // Source-register match against the EX load and every valid stage.
    always_comb begin
        hit1 = ex_load && (EX_writeReg == ID_readReg1);
        hit2 = ex_load && (EX_writeReg == ID_readReg2);
        for (int k = 0; k < SB_N; k++) begin
            hit1 = hit1 | (sb_valid[k] && (sb_reg[k] == ID_readReg1));
            hit2 = hit2 | (sb_valid[k] && (sb_reg[k] == ID_readReg2));
        end
        raw_stall = (ID_useReg1 && (ID_readReg1 != {REG_AW{1'b0}}) && hit1) ||
                    (ID_useReg2 && (ID_readReg2 != {REG_AW{1'b0}}) && hit2);
        flush_now = EX_PCSrc || (fcnt != {FW{1'b0}});
        lw_stall  = raw_stall && !flush_now;
    end

    // Pipeline controls; all forced low while reset is asserted.
    always_comb begin
        if (rst_i) begin
            stallPC    = 1'b0;
            IFID_stall = 1'b0;
            IFID_flush = 1'b0;
            IDEX_flush = 1'b0;
            sb_busy    = 1'b0;
        end else begin
            stallPC    = lw_stall;
            IFID_stall = lw_stall;
            IFID_flush = flush_now;
            IDEX_flush = lw_stall || flush_now;
            sb_busy    = |sb_valid;
        end
    end

endmodule

// File: doc/hazard_unit_ml.md
# hazard_unit_ml

Parametrised load-use and control hazard unit for the 5-stage pipeline, replacing the single-cycle load-use detector. It tracks in-flight loads through a configurable memory latency using an age-indexed scoreboard, and stalls ID until each load's result can be forwarded. It flushes wrong-path instructions for a configurable branch penalty. It sits beside the ID stage and drives the PC, IF/ID and ID/EX pipeline-register controls.

## Interface
- REG_AW, 5: register-address width.
- LOAD_LAT, 1: cycles, counted from the cycle a load occupies EX, during which a dependent ID instruction must stall. Range 1..8; 1 gives the classic one-bubble load-use.
- BR_PENALTY, 1: number of consecutive cycles IF/ID is flushed on a taken branch/jump. Range 1..4.
- clk_i  input  1  clock. One clock domain.
- rst_i  input  1  reset. Synchronous, active-high.
- ID_readReg1  input  REG_AW  source register 1 of the instruction in ID.
- ID_readReg2  input  REG_AW  source register 2 of the instruction in ID.
- ID_useReg1  input  1  ID instruction actually reads ID_readReg1.
- ID_useReg2  input  1  ID instruction actually reads ID_readReg2.
- EX_writeReg  input  REG_AW  destination register of the instruction in EX.
- EX_regWrite  input  1  EX instruction writes the register file.
- EX_memtoReg  input  2  write-back source of the EX instruction; 2'b01 marks a load.
- EX_PCSrc  input  1  taken branch/jump resolved in EX.
- stallPC  output  1  hold the PC.
- IFID_stall  output  1  hold IF/ID.
- IFID_flush  output  1  zero IF/ID.
- IDEX_flush  output  1  insert a bubble into ID/EX.
- sb_busy  output  1  at least one scoreboard stage is valid.

## Operation
- EX load: EX_memtoReg==2'b01, EX_regWrite==1, and EX_writeReg!=0.
- Scoreboard:
  - Shift register of LOAD_LAT-1 stages. Each stage holds {valid, reg}. There are no stages when LOAD_LAT==1.
  - Every clock edge, stage 0 takes {EX load, EX_writeReg}, and stage k takes stage k-1.
  - The oldest stage drops out.
  - The scoreboard shifts unconditionally. It is never stalled and never cleared by a flush, because entries are older than any branch in EX.
- Source match: (useRegN && readRegN!=0) and readRegN equals either EX_writeReg while an EX load is present, or the reg of any valid scoreboard stage.
  - Register 0 never matches.
- rawStall = match on source 1 OR source 2.
- Flush shadow:
  - Down-counter fcnt, width ceil(log2(BR_PENALTY))+1.
  - When EX_PCSrc is high, fcnt loads BR_PENALTY-1 on the edge. Otherwise it decrements while nonzero.
  - A new EX_PCSrc during the shadow reloads the counter.
- flushNow = EX_PCSrc OR (fcnt!=0).
- Outputs (combinational from inputs and registered state):
  - lwStall = rawStall AND NOT flushNow. The flush takes priority because the ID instruction is wrong-path.
  - stallPC = IFID_stall = lwStall.
  - IFID_flush = flushNow.
  - IDEX_flush = lwStall OR flushNow.
  - sb_busy = OR of the stage valids.
- Reset:
  - While rst_i is high, all outputs are 0.
  - On the edge with rst_i high, all stage valids and fcnt clear to 0.
  - A reset mid-stall or mid-shadow releases the stall or flush starting the first cycle rst_i is low.

## Timing
- Load-use latency:
  - A dependent instruction in ID stalls in the cycle the load is in EX, plus LOAD_LAT-1 further cycles.
  - It issues to EX on the edge after the last stall cycle.
  - An instruction 1 behind the load stalls LOAD_LAT cycles, 2 behind stalls LOAD_LAT-1 cycles, and so on, with a minimum of 0.
- Branch:
  - IFID_flush is high for exactly BR_PENALTY cycles, starting in the EX_PCSrc cycle.
  - IDEX_flush is high in the same cycles.
  - stallPC is 0 in all of these cycles.
- Simultaneous rawStall and EX_PCSrc: outputs are flush only (stallPC=0, IFID_stall=0, IFID_flush=1, IDEX_flush=1).
- With LOAD_LAT==1 and BR_PENALTY==1, the outputs equal the single-cycle detector, except that register 0 is exempt and flush takes priority.

## Test plan
- LOAD_LAT=1: lw x5 in EX, ID reads x5 (useReg1=1) -> one cycle with stallPC=IFID_stall=IDEX_flush=1, IFID_flush=0; next cycle all 0.
- LOAD_LAT=3: lw x7 in EX, dependent add in ID -> stall asserted 3 consecutive cycles, sb_busy high for 2 cycles after the load leaves EX. Same setup with the dependent instruction entering ID 2 cycles after the load left EX -> stall 1 cycle.
- lw x0 in EX, ID reads x0; and separately lw x5 with useReg2=0 and readReg2=5 -> no stall, all outputs 0.
- BR_PENALTY=3: EX_PCSrc pulse -> IFID_flush=IDEX_flush=1 for 3 cycles, stallPC=0. A second EX_PCSrc in shadow cycle 2 -> flush extends to 3 cycles from that point.
- lw x9 in EX with ID reading x9 and EX_PCSrc=1 in the same cycle -> stallPC=0, IFID_stall=0, IFID_flush=1, IDEX_flush=1.
- LOAD_LAT=4: rst_i high for one cycle during the second stall cycle -> outputs 0 during reset, sb_busy=0 and no stall afterwards with the same ID inputs.
